regfile_rr_scheduler: RTL and testbench

- Shares one 32x32 register file (32-to-1 read mux plus write decode) between NREQ requesters using a round-robin arbiter.
- Each granted requester gets one read or one write access per grant. At most one access is performed per clock.
- Sits between the regfile datapath and the client blocks that need register access.

---
 rtl/regfile_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_regfile_rr_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_rr_scheduler.sv
// regfile_rr_scheduler
// A 32x32 register file shared by NREQ requesters through a round-robin
// arbiter. Each edge grants at most one requester one access, either a read
// or a write. The round-robin pointer moves to the slot after the winner.
// A requester granted on the previous edge is masked for one edge, so a
// held req cannot win twice in a row.

module regfile_rr_scheduler #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int ID_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ID_W-1:0]          rid,
    output logic                     busy
);

    localparam int NREGS = 1 << ADDR_W;

    // Register storage and arbitration state
    logic [DATA_W-1:0] regs [NREGS];
    logic [ID_W-1:0]   ptr;

    // Per-requester views of the packed address and data buses
    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];

    // Arbitration results
    logic [NREQ-1:0]   elig;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_we;

    // Split the flat request buses into per-requester fields
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
    end

    // busy is the only combinational output
    assign busy = |req;

    // A requester granted on the previous edge sits out this edge
    assign elig = req & ~gnt;

    // Round-robin search: first eligible index starting at ptr, wrapping
    // naturally because NREQ is a power of two and cand is ID_W bits wide
    always_comb begin
        // NOTE: every output of this block gets a default before the loop
        // so no path leaves a value unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + ID_W'(k);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Route the winner's access fields onto the shared datapath
    always_comb begin
        win_addr  = addr_arr[win_idx];
        win_wdata = wdata_arr[win_idx];
        win_we    = we[win_idx];
    end

    // Register file write port; reset clears every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is reset explicitly because register
            // contents must read as zero after reset. That rules out a
            // RAM macro, which is acceptable at 32 entries.
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (win_found && win_we) begin
            regs[win_addr] <= win_wdata;
        end
    end

    // Grant, read-return and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt    <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
            ptr    <= '0;
        end else if (win_found) begin
            // NOTE: non-blocking assignments here let rdata capture the
            // pre-edge register value in the same edge as the pointer and
            // grant update, independent of statement order.
            gnt <= NREQ'(1) << win_idx;
            rid <= win_idx;
            ptr <= win_idx + ID_W'(1);
            if (win_we) begin
                rvalid <= 1'b0;
            end else begin
                rvalid <= 1'b1;
                rdata  <= regs[win_addr];
            end
        end else begin
            gnt    <= '0;
            rvalid <= 1'b0;
        end
    end

    // Structural invariants of the grant interface
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(gnt));
    a_rvalid_has_gnt : assert property (@(posedge clk) disable iff (reset)
        rvalid |-> (gnt != '0));

endmodule

// File: tb/tb_regfile_rr_scheduler.sv
// Self-checking bench for regfile_rr_scheduler. A behavioural model keeps the
// register contents in an array. It keeps the round-robin priority order as a
// queue: the winner is rotated to the back after each grant. Directed
// scenarios are followed by randomized traffic.

module tb_regfile_rr_scheduler;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int ID_W   = 2;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic                   rvalid;
    logic [DATA_W-1:0]      rdata;
    logic [ID_W-1:0]        rid;
    logic                   busy;

    regfile_rr_scheduler #(
        .NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .rid(rid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-requester stimulus fields, packed onto the buses by drive()
    logic [ADDR_W-1:0] a_arr [NREQ];
    logic [DATA_W-1:0] d_arr [NREQ];

    // Behavioural model state
    logic [DATA_W-1:0] m_regs [32];
    int                m_order[$];
    int                m_last;
    logic [NREQ-1:0]   exp_gnt;
    logic              exp_rvalid;
    logic [DATA_W-1:0] exp_rdata;
    logic [ID_W-1:0]   exp_rid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_order = {0, 1, 2, 3};
        m_last = -1;
        exp_gnt = '0;
        exp_rvalid = 1'b0;
        exp_rdata = '0;
        exp_rid = '0;
    endtask

    // One rising edge of the reference behaviour, using the driven inputs
    task automatic model_edge();
        int w;
        w = -1;
        foreach (m_order[k]) begin
            if (w < 0 && req[m_order[k]] && m_order[k] != m_last) w = m_order[k];
        end
        if (w >= 0) begin
            if (we[w]) begin
                m_regs[a_arr[w]] = d_arr[w];
                exp_rvalid = 1'b0;
            end else begin
                exp_rdata = m_regs[a_arr[w]];
                exp_rvalid = 1'b1;
            end
            while (m_order[$] != w) m_order.push_back(m_order.pop_front());
            exp_gnt = NREQ'(1) << w;
            exp_rid = ID_W'(w);
            m_last = w;
        end else begin
            exp_gnt = '0;
            exp_rvalid = 1'b0;
            m_last = -1;
        end
    endtask

    task automatic compare_outputs();
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("rvalid", 32'(rvalid), 32'(exp_rvalid));
        check("rdata", rdata, exp_rdata);
        check("rid", 32'(rid), 32'(exp_rid));
    endtask

    // Drive one cycle of requests at the falling edge, then check after the
    // next rising edge
    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w);
        @(negedge clk);
        req = r;
        we  = w;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*ADDR_W +: ADDR_W]  = a_arr[i];
            wdata[i*DATA_W +: DATA_W] = d_arr[i];
        end
        #1;
        check("busy", 32'(busy), 32'(r != '0));
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic clear_fields();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
        end
    endtask

    initial begin
        logic [NREQ-1:0] prev_gnt;
        int grants;

        req = '0; we = '0; addr = '0; wdata = '0;
        clear_fields();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Single read right after reset
        a_arr[0] = 5'd7;
        cycle(4'b0001, 4'b0000);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_rvalid", 32'(rvalid), 32'h1);
        check("t1_rdata", rdata, 32'h0);
        cycle(4'b0000, 4'b0000);

        // Write then read-after-write from another requester
        a_arr[1] = 5'd5; d_arr[1] = 32'hDEADBEEF;
        cycle(4'b0010, 4'b0010);
        a_arr[2] = 5'd5;
        cycle(4'b0100, 4'b0000);
        check("raw_rdata", rdata, 32'hDEADBEEF);
        check("raw_rid", 32'(rid), 32'd2);
        check("raw_rvalid", 32'(rvalid), 32'h1);
        cycle(4'b0000, 4'b0000);

        // Full load fairness
        clear_fields();
        prev_gnt = '0;
        for (int k = 0; k < 12; k++) begin
            cycle(4'b1111, 4'b0000);
            check("fl_onegrant", 32'($countones(gnt)), 32'd1);
            check("fl_rotates", 32'(gnt != prev_gnt), 32'd1);
            prev_gnt = gnt;
        end
        cycle(4'b0000, 4'b0000);

        // Held req masking: a lone held request wins every other edge
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1000, 4'b0000);
            check("held_alt", 32'(gnt[3]), 32'((k % 2) == 0));
        end
        cycle(4'b0000, 4'b0000);

        // Sweep: write i to reg i, then read all back
        grants = 0;
        for (int i = 0; i < 32; i++) begin
            a_arr[0] = 5'(i); d_arr[0] = 32'(i);
            cycle(4'b0001, 4'b0001);
            if (gnt == 4'b0001) grants++;
            cycle(4'b0000, 4'b0000);
        end
        for (int i = 0; i < 32; i++) begin
            a_arr[0] = 5'(i);
            cycle(4'b0001, 4'b0000);
            if (gnt == 4'b0001) grants++;
            check("sweep_rd", 32'(rdata[4:0]), 32'(i));
            cycle(4'b0000, 4'b0000);
        end
        check("sweep_grants", 32'(grants), 32'd64);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = 5'($urandom_range(0, 31));
                d_arr[i] = $urandom;
            end
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        cycle(4'b0000, 4'b0000);

        // Reset mid-stream while a write to reg 9 is pending
        clear_fields();
        a_arr[1] = 5'd9; d_arr[1] = 32'hCAFE0009;
        cycle(4'b0010, 4'b0010);
        cycle(4'b0000, 4'b0000);
        a_arr[2] = 5'd9;
        cycle(4'b0100, 4'b0000);
        check("pre_rst_rdata", rdata, 32'hCAFE0009);
        @(negedge clk);
        a_arr[0] = 5'd9; d_arr[0] = 32'h12345678;
        req = 4'b0001; we = 4'b0001;
        addr[0 +: ADDR_W] = 5'd9;
        wdata[0 +: DATA_W] = 32'h12345678;
        #2;
        reset = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        req = '0; we = '0;
        a_arr[3] = 5'd9;
        cycle(4'b1000, 4'b0000);
        check("rst_reg9", rdata, 32'h0);
        check("rst_rid", 32'(rid), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
